// File: rtl/video_timing_gen.sv
// -----------------------------------------------------------------------------
// video_timing_gen
//
// Video scan address / timing generator. A CNT_W-bit counter q advances once
// per clk_en. Its upper ADDR_W bits form the video address and the low PRE_W
// bits act as a pixel prescaler. Frames alternate between two lengths:
//   long frame  : q runs 0 .. all-ones        with frame_odd = 0
//   short frame : q runs RELOAD .. all-ones   with frame_odd = 1
// A parity bit (pe) selects which frame comes next.
//
// Besides the address, the block produces these outputs:
//   - a one-clk frame_start pulse at every frame boundary
//   - a region flag when the top REGION_BITS of the address equal REGION_VAL
//   - a one-clk row_strobe pulse with the row index, for an external PROM
//   - N_IRQ compare channels. Each has a match level and a sticky pending flag.
//
// All registered outputs are computed from q_next. They therefore change on
// the same edge as video_addr and have no extra latency relative to it.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   clk_en        advance enable for the counter and all timing state
//   video_addr    q[CNT_W-1:PRE_W], combinational from the counter
//   frame_odd     current frame parity (1 = short frame)
//   frame_start   one-clk pulse after the clk_en cycle that wrapped or reloaded
//   region        registered region match flag
//   row_strobe    one-clk pulse when the new q starts a row
//   row_index     row number (q bits above ROW_W), captured at row start
//   cfg_we/sel    channel configuration write strobe and channel select
//   cfg_en/mask/cmp  channel enable, compare mask and compare value
//   irq_ack       per-channel pending clear
//   irq_level     per-channel registered match level
//   irq_pend      per-channel sticky flag, set on a rising match level
// -----------------------------------------------------------------------------
module video_timing_gen #(
   parameter int                              PRE_W       = 2,
   parameter int                              ADDR_W      = 14,
   parameter logic [ADDR_W+PRE_W-1:0]         RELOAD      = 16'hFC00,
   parameter int                              ROW_W       = 8,
   parameter int                              REGION_BITS = 4,
   parameter logic [REGION_BITS-1:0]          REGION_VAL  = 4'hF,
   parameter int                              N_IRQ       = 2,
   parameter int                              SEL_W       = 1
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               clk_en,
   output logic [ADDR_W-1:0]                  video_addr,
   output logic                               frame_odd,
   output logic                               frame_start,
   output logic                               region,
   output logic                               row_strobe,
   output logic [ADDR_W+PRE_W-ROW_W-1:0]      row_index,
   input  logic                               cfg_we,
   input  logic [SEL_W-1:0]                   cfg_sel,
   input  logic                               cfg_en,
   input  logic [ADDR_W-1:0]                  cfg_mask,
   input  logic [ADDR_W-1:0]                  cfg_cmp,
   input  logic [N_IRQ-1:0]                   irq_ack,
   output logic [N_IRQ-1:0]                   irq_level,
   output logic [N_IRQ-1:0]                   irq_pend
);

   localparam int CNT_W = ADDR_W + PRE_W;
   localparam int RI_W  = CNT_W - ROW_W;

   // -------------------------------------------------------------------------
   // Counter state
   // -------------------------------------------------------------------------
   logic [CNT_W-1:0]  q_reg;
   logic              pe_reg;
   logic              frame_start_reg;
   logic              region_reg;
   logic              row_strobe_reg;
   logic [RI_W-1:0]   row_index_reg;

   logic              tc;
   logic [CNT_W-1:0]  q_next;
   logic [ADDR_W-1:0] va_next;
   logic              row_start;
   logic              region_hit;

   // The reload happens only at the end of a long frame (pe = 0). At the end
   // of a short frame the counter simply wraps to zero.
   always_comb begin
      tc         = &q_reg;
      q_next     = (tc && !pe_reg) ? RELOAD : (q_reg + CNT_W'(1));
      va_next    = q_next[CNT_W-1:PRE_W];
      row_start  = (q_next[ROW_W-1:0] == '0);
      region_hit = (va_next[ADDR_W-1 -: REGION_BITS] == REGION_VAL);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_reg           <= '0;
         pe_reg          <= 1'b0;
         frame_start_reg <= 1'b0;
         region_reg      <= 1'b0;
         row_strobe_reg  <= 1'b0;
         row_index_reg   <= '0;
      end else begin
         // The pulses are evaluated on every clk, so each one lasts exactly
         // one clk even when clk_en stays high. Once q has moved on, tc and
         // row_start are no longer true for the same count.
         frame_start_reg <= clk_en && tc;
         row_strobe_reg  <= clk_en && row_start;
         if (clk_en) begin
            q_reg      <= q_next;
            region_reg <= region_hit;
            if (tc) begin
               pe_reg <= ~pe_reg;
            end
            if (row_start) begin
               row_index_reg <= q_next[CNT_W-1:ROW_W];
            end
         end
      end
   end

   assign video_addr  = q_reg[CNT_W-1:PRE_W];
   assign frame_odd   = pe_reg;
   assign frame_start = frame_start_reg;
   assign region      = region_reg;
   assign row_strobe  = row_strobe_reg;
   assign row_index   = row_index_reg;

   // -------------------------------------------------------------------------
   // Compare interrupt channels
   // -------------------------------------------------------------------------
   // Each channel holds its own configuration. A write whose select value does
   // not equal any channel number is ignored, because no channel decodes it.
   // A write in the same cycle as a clk_en evaluation lands on the same edge,
   // so that evaluation still uses the old configuration.
   generate
      for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_ch
         localparam logic [SEL_W-1:0] CH_SEL = SEL_W'(gi);

         logic              en_reg;
         logic [ADDR_W-1:0] mask_reg;
         logic [ADDR_W-1:0] cmp_reg;
         logic              level_reg;
         logic              pend_reg;
         logic              cfg_hit;
         logic              match;

         always_comb begin
            cfg_hit = cfg_we && (cfg_sel == CH_SEL);
            match   = en_reg && ((va_next & mask_reg) == (cmp_reg & mask_reg));
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               en_reg    <= 1'b0;
               mask_reg  <= '0;
               cmp_reg   <= '0;
               level_reg <= 1'b0;
               pend_reg  <= 1'b0;
            end else begin
               if (cfg_hit) begin
                  en_reg   <= cfg_en;
                  mask_reg <= cfg_mask;
                  cmp_reg  <= cfg_cmp;
               end
               if (clk_en) begin
                  level_reg <= match;
               end
               // A new rising edge takes priority over an ack in the same
               // cycle, so the event that caused it is not lost.
               if (clk_en && match && !level_reg) begin
                  pend_reg <= 1'b1;
               end else if (irq_ack[gi]) begin
                  pend_reg <= 1'b0;
               end
            end
         end

         assign irq_level[gi] = level_reg;
         assign irq_pend[gi]  = pend_reg;
      end
   endgenerate

endmodule

// File: tb/tb_video_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_video_timing_gen
//
// Directed bench for video_timing_gen. The main instance uses the default
// timing: a 64K long frame, a 1K short frame and 256-count rows. It is built
// with a 2-bit select so that an out-of-range channel number can be driven.
//
// A second, small instance (6-bit counter, reload 6'h3C) covers the full
// long/short/long frame cycle in a few dozen clocks. The main instance could
// not run that cycle within the clock budget.
//
// Outputs are sampled 1 time unit after the active clock edge.
// -----------------------------------------------------------------------------
module tb_video_timing_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        clk_en;
   logic        cfg_we;
   logic [1:0]  cfg_sel;
   logic        cfg_en;
   logic [13:0] cfg_mask;
   logic [13:0] cfg_cmp;
   logic [1:0]  irq_ack;

   logic [13:0] video_addr;
   logic        frame_odd;
   logic        frame_start;
   logic        region;
   logic        row_strobe;
   logic [7:0]  row_index;
   logic [1:0]  irq_level;
   logic [1:0]  irq_pend;

   logic        s_clk_en;
   logic [3:0]  s_video_addr;
   logic        s_frame_odd;
   logic        s_frame_start;
   logic        s_region;
   logic        s_row_strobe;
   logic [3:0]  s_row_index;
   logic [0:0]  s_irq_level;
   logic [0:0]  s_irq_pend;

   int n_checks = 0;
   int n_errors = 0;
   int tb_q     = 0;
   int nstrobe  = 0;

   always #5 clk = ~clk;

   video_timing_gen #(
      .SEL_W (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .clk_en      (clk_en),
      .video_addr  (video_addr),
      .frame_odd   (frame_odd),
      .frame_start (frame_start),
      .region      (region),
      .row_strobe  (row_strobe),
      .row_index   (row_index),
      .cfg_we      (cfg_we),
      .cfg_sel     (cfg_sel),
      .cfg_en      (cfg_en),
      .cfg_mask    (cfg_mask),
      .cfg_cmp     (cfg_cmp),
      .irq_ack     (irq_ack),
      .irq_level   (irq_level),
      .irq_pend    (irq_pend)
   );

   video_timing_gen #(
      .PRE_W       (2),
      .ADDR_W      (4),
      .RELOAD      (6'h3C),
      .ROW_W       (2),
      .REGION_BITS (1),
      .REGION_VAL  (1'b1),
      .N_IRQ       (1),
      .SEL_W       (1)
   ) dut_s (
      .clk         (clk),
      .rst         (rst),
      .clk_en      (s_clk_en),
      .video_addr  (s_video_addr),
      .frame_odd   (s_frame_odd),
      .frame_start (s_frame_start),
      .region      (s_region),
      .row_strobe  (s_row_strobe),
      .row_index   (s_row_index),
      .cfg_we      (1'b0),
      .cfg_sel     (1'b0),
      .cfg_en      (1'b0),
      .cfg_mask    (4'h0),
      .cfg_cmp     (4'h0),
      .irq_ack     (1'b0),
      .irq_level   (s_irq_level),
      .irq_pend    (s_irq_pend)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end else begin
         $display("ok   %s value=%0h", tag, got);
      end
   endtask

   // One clock with the main clk_en at the given level; returns 1 unit after
   // the edge so outputs can be sampled.
   task automatic tick(input logic en);
      clk_en = en;
      @(posedge clk);
      #1;
      clk_en = 1'b0;
   endtask

   task automatic s_tick();
      s_clk_en = 1'b1;
      @(posedge clk);
      #1;
      s_clk_en = 1'b0;
   endtask

   task automatic run_to(input int target);
      while (tb_q < target) begin
         tick(1'b1);
         tb_q++;
      end
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_addr"},   32'(video_addr),  32'h0);
      check({tag, "_odd"},    32'(frame_odd),   32'h0);
      check({tag, "_fstart"}, 32'(frame_start), 32'h0);
      check({tag, "_region"}, 32'(region),      32'h0);
      check({tag, "_rowstb"}, 32'(row_strobe),  32'h0);
      check({tag, "_rowidx"}, 32'(row_index),   32'h0);
      check({tag, "_level"},  32'(irq_level),   32'h0);
      check({tag, "_pend"},   32'(irq_pend),    32'h0);
   endtask

   initial begin
      rst      = 1'b1;
      clk_en   = 1'b0;
      s_clk_en = 1'b0;
      cfg_we   = 1'b0;
      cfg_sel  = 2'd0;
      cfg_en   = 1'b0;
      cfg_mask = 14'h0;
      cfg_cmp  = 14'h0;
      irq_ack  = 2'b00;

      // ---- reset state ----
      tick(1'b0);
      tick(1'b0);
      check_reset_state("rst0");
      check("rst0_s_addr",  32'(s_video_addr), 32'h0);
      check("rst0_s_level", 32'(s_irq_level),  32'h0);
      check("rst0_s_pend",  32'(s_irq_pend),   32'h0);
      rst = 1'b0;
      tick(1'b0);
      check("idle_addr", 32'(video_addr), 32'h0);

      // ---- five isolated clk_en pulses -> q = 5, address 1 ----
      for (int i = 0; i < 5; i++) begin
         tick(1'b1);
         tb_q++;
         tick(1'b0);
      end
      check("t1_addr", 32'(video_addr), 32'h1);
      tick(1'b0);
      check("t1_hold", 32'(video_addr), 32'h1);
      check("t1_fstart", 32'(frame_start), 32'h0);

      // ---- configure ch0, then an out-of-range write that would match always ----
      cfg_we = 1'b1; cfg_sel = 2'd0; cfg_en = 1'b1; cfg_mask = 14'h0800; cfg_cmp = 14'h0800;
      tick(1'b0);
      cfg_we = 1'b1; cfg_sel = 2'd3; cfg_en = 1'b1; cfg_mask = 14'h0000; cfg_cmp = 14'h0000;
      tick(1'b0);
      cfg_we = 1'b0;

      // ---- row strobes through q = 0x400 ----
      while (tb_q < 'h400) begin
         tick(1'b1);
         tb_q++;
         if (row_strobe) begin
            nstrobe++;
            check("row_pos", 32'(tb_q & 'hFF), 32'h0);
            check("row_idx", 32'(row_index), 32'(tb_q >> 8));
         end
      end
      check("row_count", 32'(nstrobe), 32'd4);
      check("sel3_ignored", 32'(irq_level[1]), 32'h0);
      check("ch0_low", 32'(irq_level[0]), 32'h0);

      // ---- ch0 compare: rise at address 0x800 with a simultaneous ack ----
      run_to('h1FFF);
      check("ch0_pre", 32'(irq_level[0]), 32'h0);
      irq_ack = 2'b01;
      tick(1'b1);
      tb_q++;
      irq_ack = 2'b00;
      check("ch0_rise_addr",  32'(video_addr),   32'h0800);
      check("ch0_rise_level", 32'(irq_level[0]), 32'h1);
      check("ch0_set_wins",   32'(irq_pend[0]),  32'h1);
      irq_ack = 2'b01;
      tick(1'b0);
      irq_ack = 2'b00;
      check("ch0_ack_clear", 32'(irq_pend[0]),  32'h0);
      check("ch0_level_hold", 32'(irq_level[0]), 32'h1);
      run_to('h4000);
      check("ch0_fall_level", 32'(irq_level[0]), 32'h0);
      check("ch0_fall_pend",  32'(irq_pend[0]),  32'h0);
      run_to('h6000);
      check("ch0_rise2_level", 32'(irq_level[0]), 32'h1);
      check("ch0_rise2_pend",  32'(irq_pend[0]),  32'h1);

      // ---- region ----
      run_to('hEFFF);
      check("region_below", 32'(region), 32'h0);
      run_to('hF000);
      check("region_addr", 32'(video_addr), 32'h3C00);
      check("region_on",   32'(region),     32'h1);
      run_to('hFFFF);
      check("region_top",   32'(region),      32'h1);
      check("long_odd",     32'(frame_odd),   32'h0);
      check("long_fstart0", 32'(frame_start), 32'h0);

      // ---- reload into the short frame ----
      tick(1'b1);
      tb_q = 'hFC00;
      check("reload_addr",   32'(video_addr),  32'h3F00);
      check("reload_odd",    32'(frame_odd),   32'h1);
      check("reload_fstart", 32'(frame_start), 32'h1);
      check("reload_rowstb", 32'(row_strobe),  32'h1);
      check("reload_rowidx", 32'(row_index),   32'hFC);
      tick(1'b1);
      tb_q++;
      check("fstart_pulse", 32'(frame_start), 32'h0);
      check("short_odd",    32'(frame_odd),   32'h1);

      // ---- reset mid short frame with a pending flag ----
      run_to('hFE00);
      check("pre_rst_pend", 32'(irq_pend[0]), 32'h1);
      check("pre_rst_addr", 32'(video_addr),  32'h3F80);
      rst = 1'b1;
      tick(1'b1);
      rst = 1'b0;
      tb_q = 0;
      check_reset_state("rst1");
      run_to(4);
      check("resume_addr", 32'(video_addr), 32'h1);
      check("resume_odd",  32'(frame_odd),  32'h0);
      // The old ch0 setting would match here; a cleared config must not.
      run_to('h2000);
      check("cfg_cleared_level", 32'(irq_level[0]), 32'h0);
      check("cfg_cleared_pend",  32'(irq_pend[0]),  32'h0);
      check("cfg_cleared_odd",   32'(frame_odd),    32'h0);

      // ---- small instance: full long/short/long cycle ----
      for (int i = 0; i < 63; i++) begin
         s_tick();
      end
      check("s_long_end_addr", 32'(s_video_addr), 32'hF);
      check("s_long_end_odd",  32'(s_frame_odd),  32'h0);
      s_tick();
      check("s_reload_addr",   32'(s_video_addr),  32'hF);
      check("s_reload_odd",    32'(s_frame_odd),   32'h1);
      check("s_reload_fstart", 32'(s_frame_start), 32'h1);
      check("s_reload_rowidx", 32'(s_row_index),   32'hF);
      for (int i = 0; i < 3; i++) begin
         s_tick();
      end
      check("s_short_fstart0", 32'(s_frame_start), 32'h0);
      check("s_short_odd",     32'(s_frame_odd),   32'h1);
      check("s_short_region",  32'(s_region),      32'h1);
      s_tick();
      check("s_wrap_addr",   32'(s_video_addr),  32'h0);
      check("s_wrap_odd",    32'(s_frame_odd),   32'h0);
      check("s_wrap_fstart", 32'(s_frame_start), 32'h1);
      check("s_wrap_region", 32'(s_region),      32'h0);
      check("s_wrap_rowstb", 32'(s_row_strobe),  32'h1);
      check("s_wrap_rowidx", 32'(s_row_index),   32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
Parametrised video address/timing generator, successor to the fixed 16-bit video counter. Produces the scan address, alternating long/short frame sequencing, a region flag, and per-row strobes with row index for an external PROM lookup. Adds N_IRQ programmable compare interrupt channels with level outputs and sticky pending flags. It sits between the CPU bus/interrupt logic and the video fetch path.

Parameters:
PRE_W, 2, counter bits below the video address (pixel prescale); CNT_W = ADDR_W+PRE_W
ADDR_W, 14, video address width
RELOAD, 16'hFC00, CNT_W-bit value loaded at terminal count when frame_odd=0; must be < 2^CNT_W
ROW_W, 8, row granularity; a row starts when the low ROW_W counter bits are 0
REGION_BITS, 4, number of video address MSBs compared for region
REGION_VAL, 4'hF, region match value
N_IRQ, 2, number of compare interrupt channels (1..8)
SEL_W, 1, config select width; 2^SEL_W >= N_IRQ

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
clk_en  in  1  advance enable; all state updates only on clk_en, except config writes and acks
video_addr  out  ADDR_W  q[CNT_W-1:PRE_W], combinational from q
frame_odd  out  1  parity bit pe
frame_start  out  1  registered; high for exactly one clk cycle after the clk_en cycle that wrapped or reloaded q
region  out  1  registered region flag
row_strobe  out  1  registered one-clk pulse at row start
row_index  out  CNT_W-ROW_W  registered q_next[CNT_W-1:ROW_W], captured on row start
cfg_we  in  1  config write strobe, independent of clk_en
cfg_sel  in  SEL_W  target channel; writes with cfg_sel >= N_IRQ are ignored
cfg_en  in  1  channel enable
cfg_mask  in  ADDR_W  compare mask
cfg_cmp  in  ADDR_W  compare value
irq_ack  in  N_IRQ  per-channel pending clear
irq_level  out  N_IRQ  registered match level
irq_pend  out  N_IRQ  sticky flag, set on rising edge of irq_level

Behaviour:
- Reset: q=0, pe=0. All outputs are 0. All channels have en=0, mask=0, cmp=0.
- Terminal count: tc = (q == all ones). q_next = RELOAD when tc && !pe, otherwise q+1, modulo 2^CNT_W. pe toggles on tc.
- Frame sequence: a long frame runs 0..max with pe=0, then a short frame runs RELOAD..max with pe=1, then repeats. Default lengths are 65536 and 1024 clk_en cycles.
- frame_start is set on the clk_en cycle in which tc=1. It clears on the next clk cycle. It is a one-clk pulse even if clk_en stays high.
- va_next = q_next[CNT_W-1:PRE_W]. region <= (va_next[ADDR_W-1 -: REGION_BITS] == REGION_VAL), updated on clk_en. Outputs are therefore aligned with the updated q, with zero latency relative to video_addr.
- Row: when clk_en && q_next[ROW_W-1:0]==0, set row_strobe=1 for one clk and load row_index. Otherwise row_strobe=0 and row_index holds. A reload to RELOAD counts as a row start when RELOAD's low bits are 0.
- Channel i match: m_i = en_i && ((va_next & mask_i) == (cmp_i & mask_i)). On clk_en, irq_level[i] <= m_i; irq_level holds when clk_en is low. A disabled channel has level 0.
- Pending: set when clk_en && m_i && !irq_level[i]. Cleared by irq_ack[i] on any clk. Set and ack in the same cycle: set wins.
- Config write: takes effect for the next clk_en evaluation. A write in the same cycle as a clk_en evaluation uses the old config for that cycle. Disabling a channel clears irq_level on the next clk_en; pending is retained until acked.
- Reset asserted mid-frame returns to the reset state on the next clk, regardless of clk_en. Pending flags and config are cleared.

Test Plan:
1. Reset, then 5 clk_en pulses with idle gaps -> video_addr=1, q=5. No change on clk_en=0 cycles. All outputs 0 before the first pulse.
2. Force q=16'hFFFF, pe=0, pulse clk_en -> q=16'hFC00, frame_odd=1, frame_start high for one clk. Run 1024 clk_en -> q=0, frame_odd=0, second frame_start.
3. Count from 0 -> region goes 1 exactly when video_addr reaches 14'h3C00 (q=16'hF000). It stays 1 through 14'h3FFF and drops after wrap.
4. Count 1024 clk_en -> row_strobe pulses at q=0x100, 0x200, 0x300, 0x400 with row_index 1, 2, 3, 4. No strobe between.
5. Configure ch0 with en=1, mask=14'h0800, cmp=14'h0800, then count -> irq_level[0] rises at video_addr 14'h0800 and irq_pend[0] sets. irq_ack in the same cycle as a later rise leaves pend=1. A lone ack clears it. A write with cfg_sel=3 while N_IRQ=2 changes nothing.
6. Assert rst mid-short-frame while irq_pend=1 -> all outputs 0 and config cleared. Counting resumes from 0 with a long frame.
